// File: rtl/signal_phase_scheduler.sv
// signal_phase_scheduler: round-robin multi-phase intersection scheduler.
// Optional emergency preemption is compiled in with `define EMERGENCY_PREEMPT_EN.
module signal_phase_scheduler #(
    parameter int N_PH      = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 40,
    parameter int EXT       = 5,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_PH-1:0]          det,
    input  logic                     emerg_req,
    input  logic [$clog2(N_PH)-1:0]  emerg_phase,
    output logic [N_PH-1:0]          green,
    output logic [N_PH-1:0]          yellow,
    output logic [$clog2(N_PH)-1:0]  cur_phase,
    output logic                     phase_start,
    output logic [N_PH-1:0]          pending
);

    localparam int W = $clog2(N_PH);
    localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] EXT_M1 = TW'(EXT - 1);
    localparam logic [TW-1:0] YEL_M1 = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_M1  = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] TMAX   = '1;

    typedef enum logic [1:0] {
        IDLE, GREEN, YELLOW, ALL_RED
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   gap_q, gap_d;
    logic [W-1:0]    cur_q, cur_d;
    logic [W-1:0]    last_q, last_d;
    logic [N_PH-1:0] pend_q, pend_d;
    logic [N_PH-1:0] green_q, yellow_q;
    logic            ps_q;

    logic [N_PH-1:0] cur_oh, req, clr;
    logic [W-1:0]    sel;
    logic            enter;

    function automatic logic [N_PH-1:0] onehot(input logic [W-1:0] p);
        return N_PH'(1) << p;
    endfunction

    // First requesting phase after the last one served, wrapping around.
    function automatic logic [W-1:0] pick(input logic [N_PH-1:0] r,
                                          input logic [W-1:0] last);
        logic [W-1:0] s;
        logic         f;
        int           idx;
        s = '0;
        f = 1'b0;
        for (int k = 1; k <= N_PH; k++) begin
            idx = (int'(last) + k) % N_PH;
            if (!f && r[idx]) begin
                s = W'(idx);
                f = 1'b1;
            end
        end
        return s;
    endfunction

`ifndef EMERGENCY_PREEMPT_EN
    logic unused_emerg;
    assign unused_emerg = ^{emerg_req, emerg_phase};
`endif

    // Next-state, timers and demand latch.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        enter   = 1'b0;
        cur_oh  = (state_q == GREEN) ? onehot(cur_q) : '0;
        // Detector in this cycle counts as demand so IDLE can react at once.
        req     = (pend_q | det) & ~cur_oh;
        sel     = pick(req, last_q);

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GREEN;
                    cur_d   = sel;
                    enter   = 1'b1;
                end
            end
            GREEN: begin
                if (|req && timer_q >= MIN_M1 &&
                    (gap_q >= EXT_M1 || timer_q >= MAX_M1))
                    state_d = YELLOW;
            end
            YELLOW: begin
                if (timer_q >= YEL_M1)
                    state_d = ALL_RED;
            end
            ALL_RED: begin
                if (timer_q >= AR_M1) begin
                    if (|req) begin
                        state_d = GREEN;
                        cur_d   = sel;
                        enter   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef EMERGENCY_PREEMPT_EN
        if (emerg_req) begin
            case (state_q)
                IDLE: begin
                    state_d = GREEN;
                    cur_d   = emerg_phase;
                    enter   = 1'b1;
                end
                GREEN: begin
                    state_d = (cur_q == emerg_phase) ? GREEN : YELLOW;
                end
                ALL_RED: begin
                    if (timer_q >= AR_M1) begin
                        state_d = GREEN;
                        cur_d   = emerg_phase;
                        enter   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
`endif

        if (state_d != state_q)
            timer_d = '0;
        else
            timer_d = (timer_q == TMAX) ? timer_q : timer_q + 1'b1;

        if (state_d != state_q || state_q != GREEN || det[cur_q])
            gap_d = '0;
        else
            gap_d = (gap_q == TMAX) ? gap_q : gap_q + 1'b1;

        clr    = enter ? onehot(cur_d) : '0;
        pend_d = (pend_q | (det & ~cur_oh)) & ~clr;
        last_d = enter ? cur_d : last_q;
    end

    // State, counters and registered light outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            gap_q    <= '0;
            cur_q    <= '0;
            last_q   <= W'(N_PH - 1);
            pend_q   <= '0;
            green_q  <= '0;
            yellow_q <= '0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            gap_q    <= gap_d;
            cur_q    <= cur_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            green_q  <= (state_d == GREEN) ? onehot(cur_d) : '0;
            yellow_q <= (state_d == YELLOW) ? onehot(cur_d) : '0;
            ps_q     <= enter;
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign cur_phase   = cur_q;
    assign phase_start = ps_q;
    assign pending     = pend_q;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// tb_signal_phase_scheduler: directed checks of the phase scheduler.
// Preemption steps run only when EMERGENCY_PREEMPT_EN is defined.
module tb_signal_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] det;
    logic       emerg_req;
    logic [1:0] emerg_phase;
    logic [3:0] green, yellow, pending;
    logic [1:0] cur_phase;
    logic       phase_start;

    int tests = 0;
    int fails = 0;

    signal_phase_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .det         (det),
        .emerg_req   (emerg_req),
        .emerg_phase (emerg_phase),
        .green       (green),
        .yellow      (yellow),
        .cur_phase   (cur_phase),
        .phase_start (phase_start),
        .pending     (pending)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        det = '0;
        emerg_req = 1'b0;
        emerg_phase = '0;
        tick(2);
        reset = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        reset = 1'b1;
        det = '0;
        emerg_req = 1'b0;
        emerg_phase = '0;
        tick(2);
        chk("rst_green", 32'(green), 32'h0);
        chk("rst_yellow", 32'(yellow), 32'h0);
        chk("rst_cur", 32'(cur_phase), 32'h0);
        chk("rst_ps", 32'(phase_start), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);

        // Single demand on phase 2 from idle.
        reset = 1'b0;
        tick(5);
        det = 4'b0100;
        tick(1);
        det = '0;
        chk("t1_green", 32'(green), 32'h4);
        chk("t1_ps", 32'(phase_start), 32'h1);
        chk("t1_cur", 32'(cur_phase), 32'h2);
        chk("t1_pending", 32'(pending), 32'h0);
        tick(1);
        chk("t1_ps_drop", 32'(phase_start), 32'h0);
        tick(60);
        chk("t1_rest_green", 32'(green), 32'h4);
        chk("t1_rest_yellow", 32'(yellow), 32'h0);

        // Asynchronous reset while green.
        reset = 1'b1;
        #1;
        chk("async_rst_green", 32'(green), 32'h0);
        tick(1);
        reset = 1'b0;

        // Gap-out after min green, then full clearance to phase 1.
        det = 4'b0001;
        tick(1);
        det = 4'b0010;
        chk("t2_green0", 32'(green), 32'h1);
        chk("t2_ps0", 32'(phase_start), 32'h1);
        tick(1);
        det = '0;
        chk("t2_pending", 32'(pending), 32'h2);
        tick(8);
        chk("t2_green_last", 32'(green), 32'h1);
        tick(1);
        chk("t2_yellow_first", 32'(yellow), 32'h1);
        chk("t2_green_off", 32'(green), 32'h0);
        tick(3);
        chk("t2_yellow_last", 32'(yellow), 32'h1);
        tick(1);
        chk("t2_allred_y", 32'(yellow), 32'h0);
        chk("t2_allred_g", 32'(green), 32'h0);
        tick(1);
        chk("t2_allred2_g", 32'(green), 32'h0);
        tick(1);
        chk("t2_green1", 32'(green), 32'h2);
        chk("t2_ps1", 32'(phase_start), 32'h1);
        chk("t2_cur1", 32'(cur_phase), 32'h1);
        chk("t2_pend_clr", 32'(pending), 32'h0);

        // Max-green with the green detector held.
        do_reset();
        det = 4'b0001;
        tick(1);
        det = 4'b1001;
        tick(1);
        det = 4'b0001;
        tick(38);
        chk("t3_green39", 32'(green), 32'h1);
        chk("t3_pending", 32'(pending), 32'h8);
        tick(1);
        det = '0;
        chk("t3_yellow40", 32'(yellow), 32'h1);
        chk("t3_green40", 32'(green), 32'h0);

        // Round-robin order 2 -> 3 -> 1.
        do_reset();
        det = 4'b0100;
        tick(1);
        det = 4'b1010;
        chk("t4_green2", 32'(green), 32'h4);
        tick(1);
        det = '0;
        chk("t4_pending", 32'(pending), 32'ha);
        tick(15);
        chk("t4_green3", 32'(green), 32'h8);
        chk("t4_ps3", 32'(phase_start), 32'h1);
        chk("t4_pend3", 32'(pending), 32'h2);
        tick(9);
        chk("t4_green3_last", 32'(green), 32'h8);
        tick(1);
        chk("t4_yellow3", 32'(yellow), 32'h8);
        tick(4);
        chk("t4_allred_g", 32'(green), 32'h0);
        chk("t4_allred_y", 32'(yellow), 32'h0);
        tick(2);
        chk("t4_green1", 32'(green), 32'h2);
        chk("t4_cur1", 32'(cur_phase), 32'h1);
        chk("t4_ps1", 32'(phase_start), 32'h1);
        chk("t4_pend1", 32'(pending), 32'h0);

        // Reset during yellow, then restart on phase 1.
        do_reset();
        det = 4'b0001;
        tick(1);
        det = 4'b0010;
        tick(1);
        det = '0;
        tick(9);
        chk("t5_yellow", 32'(yellow), 32'h1);
        tick(1);
        reset = 1'b1;
        #1;
        chk("t5_rst_yellow", 32'(yellow), 32'h0);
        chk("t5_rst_green", 32'(green), 32'h0);
        chk("t5_rst_cur", 32'(cur_phase), 32'h0);
        chk("t5_rst_pend", 32'(pending), 32'h0);
        tick(1);
        reset = 1'b0;
        det = 4'b0010;
        tick(1);
        det = '0;
        chk("t5_green1", 32'(green), 32'h2);
        chk("t5_ps1", 32'(phase_start), 32'h1);

`ifdef EMERGENCY_PREEMPT_EN
        // Preempt from phase 0 to phase 3.
        do_reset();
        det = 4'b0001;
        tick(1);
        det = '0;
        tick(2);
        emerg_req = 1'b1;
        emerg_phase = 2'd3;
        det = 4'b0010;
        tick(1);
        det = '0;
        chk("em_yellow0", 32'(yellow), 32'h1);
        chk("em_green_off", 32'(green), 32'h0);
        tick(4);
        chk("em_allred_g", 32'(green), 32'h0);
        chk("em_allred_y", 32'(yellow), 32'h0);
        tick(2);
        chk("em_green3", 32'(green), 32'h8);
        chk("em_ps3", 32'(phase_start), 32'h1);
        tick(50);
        chk("em_hold3", 32'(green), 32'h8);
        chk("em_pend1", 32'(pending), 32'h2);
        emerg_req = 1'b0;
        tick(1);
        chk("em_release", 32'(yellow), 32'h8);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
